// File: rtl/foreground_pkg.sv
// Shared constants for the foreground VRAM host writer: parameter defaults,
// host register select codes, config bit positions and the writer FSM states.
package foreground_pkg;

    localparam int FG_ADDR_W     = 11;
    localparam int FG_DATA_W     = 8;
    localparam int FG_FIFO_DEPTH = 4;
    localparam int FG_ROW_STRIDE = 32;

    localparam logic [1:0] SEL_ADDR_LO = 2'd0;
    localparam logic [1:0] SEL_ADDR_HI = 2'd1;
    localparam logic [1:0] SEL_DATA    = 2'd2;
    localparam logic [1:0] SEL_CFG     = 2'd3;

    localparam int CFG_STRIDE  = 0;
    localparam int CFG_CLEAR   = 6;
    localparam int CFG_OVF_CLR = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_CLR_WAIT = 2'd2,
        ST_CLEAR    = 2'd3
    } fg_state_e;

endpackage

// File: rtl/foreground_wr_fifo.sv
// Small synchronous FIFO holding {addr, data} write entries.
// Push into a full FIFO and pop from an empty FIFO are ignored.
module foreground_wr_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    input  logic                   I_push,
    input  logic [WIDTH-1:0]       I_din,
    input  logic                   I_pop,
    output logic [WIDTH-1:0]       O_dout,
    output logic                   O_full,
    output logic                   O_empty,
    output logic [$clog2(DEPTH):0] O_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok, pop_ok;

    assign push_ok = I_push && !O_full;
    assign pop_ok  = I_pop && !O_empty;
    assign O_full  = (count == CNT_W'(DEPTH));
    assign O_empty = (count == '0);
    assign O_count = count;
    assign O_dout  = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge I_clk) begin
        if (push_ok) mem[wr_ptr] <= I_din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/foreground_vram_writer.sv
// Host-side write port for the foreground plane VRAM. Host data writes are
// queued with an auto-incrementing address and drained only on arbiter grant
// cycles; a config bit triggers a full hardware clear after the queue drains.
module foreground_vram_writer
    import foreground_pkg::*;
#(
    parameter int ADDR_W     = FG_ADDR_W,
    parameter int DATA_W     = FG_DATA_W,
    parameter int FIFO_DEPTH = FG_FIFO_DEPTH,
    parameter int ROW_STRIDE = FG_ROW_STRIDE
) (
    input  logic              I_pxl_clk,
    input  logic              I_rst,
    input  logic              I_host_wr,
    input  logic [1:0]        I_host_sel,
    input  logic [7:0]        I_host_data,
    output logic              O_host_busy,
    output logic              O_overflow,
    output logic              O_idle,
    input  logic              I_vram_grant,
    output logic              O_vram_we,
    output logic [ADDR_W-1:0] O_vram_addr,
    output logic [DATA_W-1:0] O_vram_din
);
    localparam int                ENTRY_W   = ADDR_W + DATA_W;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_STRIDE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    fg_state_e          state, state_nxt;
    logic [ADDR_W-1:0]  addr_q, clr_cnt;
    logic               stride_q;
    logic               fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count, count_nxt;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               busy_now, host_data, host_cfg;
    logic               push, drop, pop, clr_req, clr_write, we_nxt;

    // Busy is judged from registered state only, so a full FIFO refuses a
    // push even when a pop happens on the same edge.
    assign busy_now  = fifo_full || (state == ST_CLR_WAIT) || (state == ST_CLEAR);
    assign host_data = I_host_wr && (I_host_sel == SEL_DATA);
    assign host_cfg  = I_host_wr && (I_host_sel == SEL_CFG);
    assign push      = host_data && !busy_now;
    assign drop      = host_data && busy_now;
    // The FIFO is only ever non-empty in DRAIN or CLR_WAIT.
    assign pop       = I_vram_grant && !fifo_empty;
    assign clr_req   = host_cfg && I_host_data[CFG_CLEAR] &&
                       (state != ST_CLR_WAIT) && (state != ST_CLEAR);
    assign clr_write = (state == ST_CLEAR) && I_vram_grant;
    assign we_nxt    = pop || clr_write;
    assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

    foreground_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .I_clk   (I_pxl_clk),
        .I_rst   (I_rst),
        .I_push  (push),
        .I_din   ({addr_q, I_host_data[DATA_W-1:0]}),
        .I_pop   (pop),
        .O_dout  (fifo_dout),
        .O_full  (fifo_full),
        .O_empty (fifo_empty),
        .O_count (fifo_count)
    );

    // Writer FSM next state: drain queued writes, then run the clear sweep.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clr_req)   state_nxt = ST_CLR_WAIT;
                else if (push) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (clr_req)               state_nxt = ST_CLR_WAIT;
                else if (count_nxt == '0)  state_nxt = ST_IDLE;
            end
            ST_CLR_WAIT: begin
                if (fifo_empty) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (clr_write && (clr_cnt == ADDR_LAST)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Host registers, clear counter, FSM state and all registered outputs.
    always_ff @(posedge I_pxl_clk) begin
        if (I_rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            stride_q    <= 1'b0;
            clr_cnt     <= '0;
            O_overflow  <= 1'b0;
            O_host_busy <= 1'b0;
            O_idle      <= 1'b1;
            O_vram_we   <= 1'b0;
            O_vram_addr <= '0;
            O_vram_din  <= '0;
        end else begin
            state <= state_nxt;

            if (I_host_wr && (I_host_sel == SEL_ADDR_LO))
                addr_q[7:0] <= I_host_data;
            if (I_host_wr && (I_host_sel == SEL_ADDR_HI))
                addr_q[ADDR_W-1:8] <= I_host_data[ADDR_W-9:0];
            if (push)
                addr_q <= addr_q + (stride_q ? ROW_STEP : ADDR_W'(1));

            if (host_cfg) stride_q <= I_host_data[CFG_STRIDE];

            // A drop on the same edge beats an overflow clear.
            if (drop)
                O_overflow <= 1'b1;
            else if (host_cfg && I_host_data[CFG_OVF_CLR])
                O_overflow <= 1'b0;

            if (clr_req)        clr_cnt <= '0;
            else if (clr_write) clr_cnt <= clr_cnt + ADDR_W'(1);

            O_vram_we <= we_nxt;
            if (pop) begin
                O_vram_addr <= fifo_dout[ENTRY_W-1:DATA_W];
                O_vram_din  <= fifo_dout[DATA_W-1:0];
            end else if (clr_write) begin
                O_vram_addr <= clr_cnt;
                O_vram_din  <= '0;
            end

            O_host_busy <= (count_nxt == CNT_FULL) ||
                           (state_nxt == ST_CLR_WAIT) || (state_nxt == ST_CLEAR);
            O_idle      <= (state_nxt == ST_IDLE) && !we_nxt;
        end
    end

endmodule

// File: tb/tb_foreground_vram_writer.sv
// Scoreboard bench for foreground_vram_writer: expected VRAM writes are queued
// as host stimulus is driven and matched by a monitor as writes appear.
module tb_foreground_vram_writer;
    import foreground_pkg::*;

    localparam int AW = 11;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          I_rst = 1'b1;
    logic          I_host_wr = 1'b0;
    logic [1:0]    I_host_sel = 2'd0;
    logic [7:0]    I_host_data = 8'd0;
    logic          I_vram_grant = 1'b0;
    logic          O_host_busy, O_overflow, O_idle, O_vram_we;
    logic [AW-1:0] O_vram_addr;
    logic [DW-1:0] O_vram_din;

    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] exp_e;
    bit               mon_en = 1'b1;
    int               pass_cnt = 0;
    int               total_cnt = 0;

    foreground_vram_writer dut (
        .I_pxl_clk    (clk),
        .I_rst        (I_rst),
        .I_host_wr    (I_host_wr),
        .I_host_sel   (I_host_sel),
        .I_host_data  (I_host_data),
        .O_host_busy  (O_host_busy),
        .O_overflow   (O_overflow),
        .O_idle       (O_idle),
        .I_vram_grant (I_vram_grant),
        .O_vram_we    (O_vram_we),
        .O_vram_addr  (O_vram_addr),
        .O_vram_din   (O_vram_din)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every VRAM write must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && O_vram_we) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write got addr=%h din=%h, none expected",
                         O_vram_addr, O_vram_din);
            end else begin
                exp_e = exp_q.pop_front();
                if ({O_vram_addr, O_vram_din} !== exp_e)
                    $display("FAIL vram_write got addr=%h din=%h, expected addr=%h din=%h",
                             O_vram_addr, O_vram_din, exp_e[AW+DW-1:DW], exp_e[DW-1:0]);
                else
                    pass_cnt++;
            end
        end
    end

    // Drive one host access; returns at the next negedge with the strobe low.
    task automatic host_write(input logic [1:0] sel, input logic [7:0] data);
        I_host_wr   = 1'b1;
        I_host_sel  = sel;
        I_host_data = data;
        @(negedge clk);
        I_host_wr   = 1'b0;
    endtask

    task automatic set_addr(input logic [AW-1:0] a);
        logic [15:0] a16;
        a16 = 16'(a);
        host_write(SEL_ADDR_LO, a16[7:0]);
        host_write(SEL_ADDR_HI, a16[15:8]);
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (O_idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({O_vram_we, O_vram_addr, O_vram_din, O_host_busy, O_overflow, O_idle} !==
            {1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b1})
            $display("FAIL reset_values got we=%b addr=%h din=%h busy=%b ovf=%b idle=%b, expected 0 000 00 0 0 1",
                     O_vram_we, O_vram_addr, O_vram_din, O_host_busy, O_overflow, O_idle);
        else pass_cnt++;
        I_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        I_vram_grant = 1'b1;
        set_addr(11'h234);
        exp_q.push_back({11'h234, 8'hAA});
        exp_q.push_back({11'h235, 8'hBB});
        host_write(SEL_DATA, 8'hAA);
        total_cnt++;
        if (O_vram_we !== 1'b0) $display("FAIL basic_no_bypass got we=%b expected 0", O_vram_we);
        else pass_cnt++;
        host_write(SEL_DATA, 8'hBB);
        total_cnt++;
        if (O_vram_we !== 1'b1) $display("FAIL basic_latency got we=%b expected 1", O_vram_we);
        else pass_cnt++;
        wait_idle(20, ok);
        total_cnt++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL basic_idle got idle_seen=%0d pending=%0d expected 1 0", ok, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_stride;
        bit ok;
        I_vram_grant = 1'b1;
        host_write(SEL_CFG, 8'h01);
        set_addr(11'h7F0);
        exp_q.push_back({11'h7F0, 8'hC1});
        exp_q.push_back({11'h010, 8'hC2});
        exp_q.push_back({11'h030, 8'hC3});
        host_write(SEL_DATA, 8'hC1);
        host_write(SEL_DATA, 8'hC2);
        host_write(SEL_DATA, 8'hC3);
        wait_idle(20, ok);
        total_cnt++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL stride_drain got idle_seen=%0d pending=%0d expected 1 0", ok, exp_q.size());
        else pass_cnt++;
        host_write(SEL_CFG, 8'h00);
    endtask

    task automatic test_overflow;
        bit ok;
        I_vram_grant = 1'b0;
        set_addr(11'h100);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({11'h100 + 11'(i), 8'h11 + 8'(i)});
            host_write(SEL_DATA, 8'h11 + 8'(i));
            if (i == 2 || i == 3) begin
                total_cnt++;
                if (O_host_busy !== (i == 3))
                    $display("FAIL ovf_busy_after_%0d got %b expected %b", i + 1, O_host_busy, i == 3);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (O_overflow !== 1'b1) $display("FAIL ovf_sticky got %b expected 1", O_overflow);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (O_vram_we !== 1'b0 || O_host_busy !== 1'b1)
            $display("FAIL ovf_hold got we=%b busy=%b expected 0 1", O_vram_we, O_host_busy);
        else pass_cnt++;
        I_vram_grant = 1'b1;
        wait_idle(20, ok);
        total_cnt++;
        if (!ok || exp_q.size() != 0 || O_overflow !== 1'b1)
            $display("FAIL ovf_drain got idle_seen=%0d pending=%0d ovf=%b expected 1 0 1",
                     ok, exp_q.size(), O_overflow);
        else pass_cnt++;
        host_write(SEL_CFG, 8'h80);
        total_cnt++;
        if (O_overflow !== 1'b0) $display("FAIL ovf_clear got %b expected 0", O_overflow);
        else pass_cnt++;
        // The dropped write must not have advanced the address.
        exp_q.push_back({11'h104, 8'h16});
        host_write(SEL_DATA, 8'h16);
        wait_idle(20, ok);
        total_cnt++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL ovf_addr_kept got idle_seen=%0d pending=%0d expected 1 0", ok, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_clear;
        bit ok;
        int busy_gap;
        I_vram_grant = 1'b0;
        set_addr(11'h300);
        exp_q.push_back({11'h300, 8'h01});
        exp_q.push_back({11'h301, 8'h02});
        host_write(SEL_DATA, 8'h01);
        host_write(SEL_DATA, 8'h02);
        for (int a = 0; a < 2048; a++) exp_q.push_back({11'(a), 8'h00});
        host_write(SEL_CFG, 8'h40);
        total_cnt++;
        if (O_host_busy !== 1'b1) $display("FAIL clear_busy_start got %b expected 1", O_host_busy);
        else pass_cnt++;
        I_vram_grant = 1'b1;
        ok = 1'b0;
        busy_gap = 0;
        for (int i = 0; i < 2200; i++) begin
            @(negedge clk);
            if (O_idle === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (O_host_busy !== 1'b1 && !(O_vram_we === 1'b1 && O_vram_addr === 11'h7FF))
                busy_gap++;
        end
        total_cnt++;
        if (!ok || exp_q.size() != 0 || busy_gap != 0)
            $display("FAIL clear_sweep got idle_seen=%0d pending=%0d busy_gaps=%0d expected 1 0 0",
                     ok, exp_q.size(), busy_gap);
        else pass_cnt++;
        exp_q.push_back({11'h302, 8'h5A});
        host_write(SEL_DATA, 8'h5A);
        wait_idle(20, ok);
        total_cnt++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL clear_addr_kept got idle_seen=%0d pending=%0d expected 1 0", ok, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_grant_toggle;
        bit ok;
        bit exp_we;
        int left;
        I_vram_grant = 1'b0;
        set_addr(11'h400);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({11'h400 + 11'(i), 8'h70 + 8'(i)});
            host_write(SEL_DATA, 8'h70 + 8'(i));
        end
        left = 4;
        for (int i = 0; i < 10; i++) begin
            I_vram_grant = (i % 2 == 0);
            exp_we = I_vram_grant && (left > 0);
            if (exp_we) left--;
            @(negedge clk);
            total_cnt++;
            if (O_vram_we !== exp_we)
                $display("FAIL toggle_we_cycle_%0d got %b expected %b", i, O_vram_we, exp_we);
            else pass_cnt++;
        end
        I_vram_grant = 1'b1;
        wait_idle(20, ok);
        total_cnt++;
        if (!ok || exp_q.size() != 0)
            $display("FAIL toggle_drain got idle_seen=%0d pending=%0d expected 1 0", ok, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_clear;
        bit hit;
        mon_en = 1'b0;
        I_vram_grant = 1'b1;
        host_write(SEL_CFG, 8'h40);
        hit = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (O_vram_we === 1'b1 && O_vram_addr === 11'h100) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total_cnt++;
        if (!hit) $display("FAIL rst_mid_clear_reach got reached=0 expected 1");
        else pass_cnt++;
        I_rst = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({O_vram_we, O_vram_addr, O_vram_din, O_host_busy, O_overflow, O_idle} !==
            {1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 1'b1})
            $display("FAIL rst_mid_clear got we=%b addr=%h din=%h busy=%b ovf=%b idle=%b, expected 0 000 00 0 0 1",
                     O_vram_we, O_vram_addr, O_vram_din, O_host_busy, O_overflow, O_idle);
        else pass_cnt++;
        I_rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (O_vram_we !== 1'b0 || O_idle !== 1'b1)
            $display("FAIL rst_clear_abandoned got we=%b idle=%b expected 0 1", O_vram_we, O_idle);
        else pass_cnt++;
        mon_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_overflow();
        test_clear();
        test_grant_toggle();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
